// File: rtl/eth_frame_gen.sv
// 10BASE-T frame transmitter: byte-wise payload buffer, Manchester-coded serialiser with CRC-32 FCS.
// Optional normal-link-pulse generation is enabled by defining ETH_FRAME_GEN_NLP_EN.
module eth_frame_gen #(
    parameter int unsigned BIT_DIV    = 5,
    parameter int unsigned BUF_DEPTH  = 64,
    parameter int unsigned NLP_PERIOD = 1_600_000,
    parameter int unsigned NLP_WIDTH  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        transmit,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] eth_type,
    output logic        tx_w,
    output logic        eth_data_s,
    output logic        tx_en,
    output logic        done,
    output logic        buf_full
);
    localparam int unsigned AddrW   = $clog2(BUF_DEPTH);
    localparam int unsigned CountW  = AddrW + 1;
    localparam int unsigned HalfW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [31:0] CrcPoly = 32'hEDB88320;

    typedef enum logic [2:0] {
        StIdle, StPre, StSfd, StHdr, StPay, StPad, StFcs, StEtd
    } state_e;

    state_e            state_q, state_d;
    logic [HalfW-1:0]  half_cnt_q, half_cnt_d;
    logic              half_q, half_d;
    logic [2:0]        bit_q, bit_d;
    logic [CountW-1:0] byte_q, byte_d;
    logic [CountW-1:0] count_q, count_d;
    logic [CountW-1:0] len_q, len_d;
    logic [111:0]      hdr_q, hdr_d;
    logic [31:0]       crc_q, crc_d;
    logic [7:0]        mem [BUF_DEPTH];

    logic       nlp_active;
    logic       start;
    logic       wr_ok;
    logic       bit_end;
    logic       byte_end;
    logic       cur_bit;
    logic [7:0] cur_byte;

    assign bit_end  = half_q && (half_cnt_q == HalfW'(BIT_DIV - 1));
    assign byte_end = bit_end && (bit_q == 3'd7);
    assign wr_ok    = wr_en && (state_q == StIdle) && !buf_full && !start && !reset;
    assign buf_full = (count_q == CountW'(BUF_DEPTH));

`ifdef ETH_FRAME_GEN_NLP_EN
    localparam int unsigned NlpSpan = NLP_PERIOD + NLP_WIDTH;
    localparam int unsigned NlpW    = $clog2(NlpSpan);

    logic [NlpW-1:0] nlp_cnt_q, nlp_cnt_d;
    logic            pend_q, pend_d;

    // Counter values at or above NLP_PERIOD form the pulse window.
    assign nlp_active = (state_q == StIdle) && (nlp_cnt_q >= NlpW'(NLP_PERIOD));
    assign start      = (state_q == StIdle) && (transmit || pend_q) && !nlp_active;

    always_comb begin
        nlp_cnt_d = nlp_cnt_q;
        pend_d    = pend_q;
        if (done) begin
            nlp_cnt_d = '0;
        end else if (state_q == StIdle) begin
            nlp_cnt_d = (nlp_cnt_q == NlpW'(NlpSpan - 1)) ? '0 : nlp_cnt_q + NlpW'(1);
        end
        if (start) begin
            pend_d = 1'b0;
        end else if (nlp_active && transmit) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nlp_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            nlp_cnt_q <= nlp_cnt_d;
            pend_q    <= pend_d;
        end
    end
`else
    logic unused_nlp;

    assign nlp_active = 1'b0;
    assign start      = (state_q == StIdle) && transmit;
    assign unused_nlp = ^{NLP_PERIOD, NLP_WIDTH};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions happen only on byte (or ETD bit) boundaries.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StPre;
            StPre:  if (byte_end && byte_q == CountW'(6)) state_d = StSfd;
            StSfd:  if (byte_end) state_d = StHdr;
            StHdr: begin
                if (byte_end && byte_q == CountW'(13)) begin
                    state_d = (len_q == '0) ? StPad : StPay;
                end
            end
            StPay: begin
                if (byte_end && byte_q == len_q - CountW'(1)) begin
                    state_d = (len_q >= CountW'(46)) ? StFcs : StPad;
                end
            end
            StPad:  if (byte_end && (byte_q + len_q) == CountW'(45)) state_d = StFcs;
            StFcs:  if (byte_end && byte_q == CountW'(3)) state_d = StEtd;
            StEtd:  if (bit_end && bit_q == 3'd1) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Byte source for the bit currently on the line.
    always_comb begin
        cur_byte = 8'h00;
        unique case (state_q)
            StPre:   cur_byte = 8'h55;
            StSfd:   cur_byte = 8'hD5;
            StHdr:   cur_byte = hdr_q[111:104];
            StPay:   cur_byte = mem[byte_q[AddrW-1:0]];
            default: cur_byte = 8'h00;
        endcase
        cur_bit = (state_q == StFcs) ? ~crc_q[0] : cur_byte[bit_q];
    end

    // Datapath next-state
    always_comb begin
        half_cnt_d = half_cnt_q;
        half_d     = half_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        hdr_d      = hdr_q;
        crc_d      = crc_q;
        len_d      = len_q;
        count_d    = count_q;
        if (state_q == StIdle) begin
            half_cnt_d = '0;
            half_d     = 1'b0;
            bit_d      = '0;
            byte_d     = '0;
            if (start) begin
                hdr_d = {dst_mac, src_mac, eth_type};
                len_d = count_q;
                crc_d = '1;
            end else if (wr_ok) begin
                count_d = count_q + CountW'(1);
            end
        end else begin
            if (half_cnt_q == HalfW'(BIT_DIV - 1)) begin
                half_cnt_d = '0;
                half_d     = ~half_q;
            end else begin
                half_cnt_d = half_cnt_q + HalfW'(1);
            end
            if (bit_end) begin
                bit_d = bit_q + 3'd1;
                if (state_q inside {StHdr, StPay, StPad}) begin
                    crc_d = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ cur_bit) ? CrcPoly : 32'h0);
                end else if (state_q == StFcs) begin
                    // FCS bits are taken from crc_q[0]; shift the remainder out.
                    crc_d = {1'b1, crc_q[31:1]};
                end
            end
            if (byte_end) begin
                byte_d = (state_d != state_q) ? '0 : byte_q + CountW'(1);
                if (state_q == StHdr) begin
                    hdr_d = {hdr_q[103:0], 8'h00};
                end
            end
            if (done) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half_cnt_q <= '0;
            half_q     <= 1'b0;
            bit_q      <= '0;
            byte_q     <= '0;
            hdr_q      <= '0;
            crc_q      <= '1;
            len_q      <= '0;
            count_q    <= '0;
        end else begin
            half_cnt_q <= half_cnt_d;
            half_q     <= half_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            hdr_q      <= hdr_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[count_q[AddrW-1:0]] <= wr_data;
        end
    end

    // Outputs: bit 1 is low-then-high, bit 0 high-then-low.
    always_comb begin
        tx_w  = (state_q != StIdle);
        tx_en = tx_w || nlp_active;
        done  = (state_q == StEtd) && bit_end && (bit_q == 3'd1);
        if (state_q == StIdle) begin
            eth_data_s = nlp_active;
        end else if (state_q == StEtd) begin
            eth_data_s = 1'b1;
        end else begin
            eth_data_s = half_q ? cur_bit : ~cur_bit;
        end
    end

endmodule

// File: doc/eth_frame_gen.md
# eth_frame_gen

Parametrised 10BASE-T Ethernet frame transmitter. It buffers a payload written byte-wise and, on a `transmit` request, serialises a complete frame onto a single Manchester-coded line. The frame is preamble, SFD, MAC header, payload with zero padding, and CRC-32 FCS. It sits between the packet-building logic and the line driver.

## Interface
Parameters:
- `BIT_DIV`, 5: clk cycles per Manchester half-bit. Bit time is 2·BIT_DIV cycles; 100 MHz clk gives 10 Mb/s.
- `BUF_DEPTH`, 64: payload buffer size in bytes, power of two, ≥ 46. Maximum payload length.
- `NLP_PERIOD`, 1_600_000: idle cycles between normal link pulses (16 ms at 100 MHz).
- `NLP_WIDTH`, 10: link-pulse width in cycles.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_en` in 1: payload byte write strobe.
- `wr_data` in 8: payload byte.
- `transmit` in 1: start request, level-sampled.
- `dst_mac` in 48: destination MAC, sampled at frame start.
- `src_mac` in 48: source MAC, sampled at frame start.
- `eth_type` in 16: EtherType/length, sampled at frame start.
- `tx_w` out 1: busy; high from frame start until end of frame.
- `eth_data_s` out 1: Manchester line data.
- `tx_en` out 1: line driver enable.
- `done` out 1: one-cycle pulse at end of frame.
- `buf_full` out 1: payload buffer holds BUF_DEPTH bytes.

## Operation
- **Buffer writes.** The buffer is write-only while idle. A write with `wr_en` & !`tx_w` & !`buf_full` stores the byte at `count` and increments `count`. All other writes are dropped silently.
- **Frame start.** `transmit` & !`tx_w` (and no NLP pulse active) accepts a frame. Accepting a frame:
  - latches `dst_mac`, `src_mac`, `eth_type` and `len = count`;
  - drops any `wr_en` in the same cycle.
- **FSM states:** IDLE → PRE (7×0x55) → SFD (0xD5) → HDR (dst, src, type; 14 bytes) → PAY (`len` bytes) → PAD (max(0, 46−len) bytes of 0x00) → FCS (4 bytes) → ETD → IDLE.
  - When `len` = 0, PAY is skipped.
  - When `len` ≥ 46, PAD is skipped.
- **Byte order.**
  - Each byte is sent LSB first.
  - Multi-byte header fields are sent most-significant byte first (`dst_mac[47:40]` first).
- **FCS (CRC-32).**
  - Covers HDR+PAY+PAD.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, output complemented.
  - Sent low byte first, LSB first.
  - The CRC register updates one bit per bit time.
- **Manchester coding.**
  - Bit 1: first half low, second half high.
  - Bit 0: first half high, second half low.
- **ETD.** `eth_data_s` is held high for 2 bit times, then driven 0, `tx_en` is cleared, `done` pulses, `tx_w` clears, and `count` is cleared to 0.
- **Bounds.** `count` width is clog2(BUF_DEPTH)+1. Frame length in bytes = 8 + 14 + max(len,46) + 4.

## Timing
- **Reset values:** `tx_w`=0, `eth_data_s`=0, `tx_en`=0, `done`=0, `buf_full`=0. Also `count`=0, FSM=IDLE, NLP counter=0.
- **Start latency.** A `transmit` sampled high at edge N makes `tx_w`, `tx_en` and the first half-bit of the preamble valid from N+1.
- **Frame duration.** The frame spans (frame_bytes·8 + 2)·2·BIT_DIV cycles from N+1. At the last cycle of ETD, `done`=1 and `tx_w` goes low on the following edge.
- **Back-to-back frames.** A new `transmit` is accepted earliest the cycle after `done`.
- **Reset mid-frame.** FSM returns to IDLE next edge, the line drops to 0, the buffer empties and no `done` is issued.
- **`buf_full`.** Asserts the cycle after the BUF_DEPTH-th accepted write.
- **`transmit` while busy** is ignored; it is not queued.

## Configuration
- `ETH_FRAME_GEN_NLP_EN` defined:
  - In IDLE, the NLP counter increments. On reaching NLP_PERIOD, `eth_data_s`=1 and `tx_en`=1 for NLP_WIDTH cycles, then the counter restarts at 0.
  - The counter also restarts at `done`.
  - A `transmit` during a pulse is held pending and accepted the cycle after the pulse ends.
- Not defined:
  - No link pulses; the line stays 0 when idle.
  - No pending logic; `transmit` is accepted immediately when idle.

## Test plan
- **46-byte frame.** BIT_DIV=5; write 0x00..0x2D, dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0800, `transmit`.
  - The decoded bitstream matches the software model, including FCS.
  - Duration is 578 bit times = 5780 cycles.
  - `done` fires once.
- **Short payload.** Write 3 bytes 0xA1 0xB2 0xC3.
  - 43 zero pad bytes follow; the frame is 72 bytes.
  - FCS matches the model.
  - `tx_w` stays high for 5780 cycles.
- **Overflow.** Write 65 bytes with BUF_DEPTH=64.
  - `buf_full`=1 after the 64th write; the 65th is dropped.
  - The frame carries 64 payload bytes.
- **Busy / same-cycle collisions.**
  - A second `transmit` and writes issued while `tx_w`=1 are ignored.
  - A `wr_en` in the same cycle as `transmit` is dropped.
- **Reset mid-frame.** Assert `reset` in HDR.
  - Next cycle `eth_data_s`=0, `tx_en`=0, `tx_w`=0.
  - No `done`; `count`=0.
- **NLP (macro on, NLP_PERIOD=100, NLP_WIDTH=10).**
  - An idle pulse appears every 110 cycles.
  - A `transmit` at pulse cycle 3 starts the frame 8 cycles later.
